seq_match_scheduler: RTL and testbench
======================================

// Module: seq_match_scheduler
// PURPOSE
//   Shares one bit-serial "110" sequence-detector core between N_REQ requesters.
//   Grants requesters round-robin and latches the granted WORD_W-bit word.
//   Shifts the word MSB-first into the detector, one bit per clock.
//   Returns the number of pattern hits in that word to the granted requester.
//   Sits between the word-level client channels and the single shared detector datapath.
// PARAMETERS
//   N_REQ    4       number of requester channels (>=2)
//   WORD_W   8       bits per request word (>=PAT_LEN)
//   PATTERN  3'b110  pattern to count, first-received bit is MSB
//   CNT_W    derived $clog2(WORD_W+1), localparam, not overridable
// PORTS
//   clock       in   1            single clock, rising edge
//   reset       in   1            asynchronous, active-low reset
//   req_valid   in   N_REQ        channel i has a word pending
//   req_data    in   N_REQ*WORD_W channel i word at [i*WORD_W +: WORD_W]
//   req_ready   out  N_REQ        one-hot; one-cycle pulse = word accepted
//   resp_valid  out  N_REQ        one-hot; one-cycle pulse = result for channel i
//   resp_count  out  CNT_W        hit count; valid only while resp_valid != 0
//   busy        out  1            high in LOAD/SHIFT/DONE
//   grant_id    out  $clog2(N_REQ) index of current/last granted channel
// BEHAVIOUR
//   Reset (reset==0):
//     - all outputs 0; state IDLE; hit history and counter 0
//     - round-robin pointer = N_REQ-1, so channel 0 is granted first
//   FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//   IDLE: if req_valid != 0, select the first set bit searching from pointer+1 (wrapping).
//     Go to LOAD. Otherwise stay in IDLE.
//   LOAD (1 cycle):
//     - req_ready[g]=1 for this cycle only
//     - capture req_data[g]; clear history and counter; pointer <= g; grant_id <= g
//   SHIFT (exactly WORD_W cycles): each cycle, shift the next bit (MSB first) into
//     the PAT_LEN-bit history. If the history plus the incoming bit equals PATTERN and
//     at least PAT_LEN bits of this word have been shifted, increment the counter.
//   DONE (1 cycle): resp_valid[g]=1 and resp_count=counter, then go to IDLE.
//   Timing:
//     - req_ready in cycle T -> resp_valid in cycle T+WORD_W+1
//     - minimum grant spacing is WORD_W+3 cycles (IDLE is always visited)
//   Handshake: requesters hold req_valid and req_data stable until req_ready.
//     - dropping req_valid before grant withdraws the request with no side effects
//     - data may change in the cycle after req_ready
//   Overlapping matches are counted. Pattern history never carries across words:
//     it is cleared in LOAD.
//   Counter cannot overflow: max hits = WORD_W-PAT_LEN+1 < 2^CNT_W.
//   A new req_valid on the granted channel during SHIFT/DONE waits for its next round-robin turn.
//   Reset asserted mid-operation aborts the word: no resp_valid, and the pointer returns to N_REQ-1.
//   Simultaneous requests are never granted in the same cycle: exactly one grant per LOAD.
// STRUCTURE
//   Package seq_match_pkg:
//     - state encoding localparams IDLE/LOAD/SHIFT/DONE
//     - default PATTERN and PAT_LEN=3
//     - clog2 helper
//   Sub-module seq_match_core: history shift register, bit counter, hit counter.
//     Ports: clock, reset, clear, shift_en, bit_in, count.
//   Top level contains the round-robin arbiter, the FSM, and the word shift register.
// TESTING (WORD_W=8, N_REQ=4, PATTERN=110)
//   1. reset=0 with req_valid=4'b1111 -> req_ready=0, resp_valid=0, busy=0 throughout
//   2. ch0 only, data 8'b1101_1000, ready at T -> resp_valid=4'b0001 at T+9, count=2
//   3. ch1 words 8'hFF, 8'h00, 8'b0110_0110, 8'b1100_1100 -> counts 0, 0, 2, 2
//   4. all four valid from reset release -> req_ready order ch0,ch1,ch2,ch3
//      - spaced 11 cycles apart; grant_id follows 0,1,2,3
//   5. ch3 word 8'b0000_0011, then 8'b0000_0000 -> both counts 0 (no cross-word hit)
//   6. reset pulled low during SHIFT of ch2, then all valid -> no resp for ch2; next grant ch0

Source files
------------

// File: rtl/seq_match_pkg.sv
// Shared types and constants for the bit-serial "110" match scheduler.
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int                 PAT_LEN     = 3;
  localparam logic [PAT_LEN-1:0] DEF_PATTERN = 3'b110;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern detector: PAT_LEN-bit history, bits-seen counter and hit counter.
module seq_match_core
  import seq_match_pkg::*;
#(
  parameter int                 WORD_W  = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  localparam int                CNT_W   = clog2(WORD_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  localparam int                NB_W   = clog2(PAT_LEN);
  localparam logic [NB_W-1:0]   NB_MAX = NB_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_hist;
  logic [NB_W-1:0]    r_nbits;
  logic [CNT_W-1:0]   r_cnt;
  logic [PAT_LEN-1:0] w_window;
  logic               w_hit;

  // A hit needs PAT_LEN real bits of this word, so reset zeros never form a match.
  assign w_window = {r_hist[PAT_LEN-2:0], bit_in};
  assign w_hit    = shift_en && (w_window == PATTERN) && (r_nbits == NB_MAX);
  assign count    = r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_nbits <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_hist  <= '0;
      r_nbits <= '0;
      r_cnt   <= '0;
    end else if (shift_en) begin
      r_hist <= w_window;
      if (r_nbits != NB_MAX) r_nbits <= r_nbits + NB_W'(1);
      if (w_hit)             r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_match_scheduler.sv
// Round-robin front end sharing one seq_match_core between N_REQ word requesters.
module seq_match_scheduler
  import seq_match_pkg::*;
#(
  parameter int                 N_REQ   = 4,
  parameter int                 WORD_W  = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  localparam int                CNT_W   = clog2(WORD_W + 1),
  localparam int                GID_W   = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [CNT_W-1:0]        resp_count,
  output logic                    busy,
  output logic [GID_W-1:0]        grant_id
);

  localparam int              BC_W    = (WORD_W > 1) ? clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  state_t            r_state, w_next;
  logic [GID_W-1:0]  r_ptr, r_sel, r_grant_id, w_sel;
  logic              w_found;
  logic [WORD_W-1:0] r_word, w_word;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]  w_count;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_found && req_valid[(int'(r_ptr) + i) % N_REQ]) begin
        w_found = 1'b1;
        w_sel   = GID_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_REQ; i++)
      if (r_sel == GID_W'(i)) w_word = req_data[i*WORD_W +: WORD_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (r_bit_cnt == BC_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_count = '0;
    if (r_state == LOAD) req_ready[r_sel] = 1'b1;
    if (r_state == DONE) begin
      resp_valid[r_sel] = 1'b1;
      resp_count        = w_count;
    end
  end

  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant_id;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr      <= GID_W'(N_REQ - 1);
      r_sel      <= '0;
      r_grant_id <= '0;
      r_word     <= '0;
      r_bit_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_found) r_sel <= w_sel;
        LOAD: begin
          r_word     <= w_word;
          r_ptr      <= r_sel;
          r_grant_id <= r_sel;
          r_bit_cnt  <= '0;
        end
        SHIFT: begin
          r_word    <= {r_word[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  seq_match_core #(
    .WORD_W  (WORD_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .clear    (r_state == LOAD),
    .shift_en (r_state == SHIFT),
    .bit_in   (r_word[WORD_W-1]),
    .count    (w_count)
  );

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Scoreboard bench for seq_match_scheduler with directed words and hand-computed hit counts.
module tb_seq_match_scheduler;

  localparam int N_REQ   = 4;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 4;
  localparam int GID_W   = 2;
  localparam int LAT     = WORD_W + 1;
  localparam int SPACING = WORD_W + 3;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*WORD_W-1:0] req_data  = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [CNT_W-1:0]        resp_count;
  logic                    busy;
  logic [GID_W-1:0]        grant_id;

  seq_match_scheduler #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_count (resp_count),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int ch; int cnt; } exp_t;
  exp_t exp_q[$];
  int   rdy_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  always @(negedge clock) begin
    if (req_ready != '0) begin
      check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      rdy_q.push_back(cyc);
    end
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("resp_channel", 32'(resp_valid), 32'(1 << mon_e.ch));
        check("resp_count", 32'(resp_count), 32'(mon_e.cnt));
      end
      if (rdy_q.size() == 0) check("resp_without_ready", 32'(resp_valid), 32'd0);
      else                   check("resp_latency", 32'(cyc - rdy_q.pop_front()), 32'(LAT));
    end
  end

  task automatic wait_ready_any(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clock);
      if (req_ready != '0) ok = 1'b1;
    end
    if (!ok) check("ready_timeout", 32'(req_ready), 32'hF);
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic send(input int ch, input logic [WORD_W-1:0] data, input int cnt);
    logic ok;
    exp_q.push_back('{ch, cnt});
    req_data[ch*WORD_W +: WORD_W] = data;
    req_valid[ch] = 1'b1;
    wait_ready_any(ok);
    if (ok) begin
      check("ready_channel", 32'(req_ready), 32'(1 << ch));
      check("busy_in_load", 32'(busy), 32'd1);
    end
    @(posedge clock); #1;
    req_valid[ch] = 1'b0;
    req_data[ch*WORD_W +: WORD_W] = ~data;
    wait_drain();
  endtask

  // All four channels valid out of reset: expect ch0..ch3, 11 cycles apart.
  task automatic run_all();
    logic ok;
    int   last = 0;
    req_data  = {8'hFE, 8'hC0, 8'h66, 8'hD8};
    req_valid = 4'b1111;
    exp_q.push_back('{0, 2});
    exp_q.push_back('{1, 2});
    exp_q.push_back('{2, 1});
    exp_q.push_back('{3, 1});
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      wait_ready_any(ok);
      if (ok) begin
        check("grant_order", 32'(req_ready), 32'(1 << k));
        if (k > 0) check("grant_spacing", 32'(cyc - last), 32'(SPACING));
        last = cyc;
      end
      @(posedge clock); #1;
      req_valid[k] = 1'b0;
      check("grant_id", 32'(grant_id), 32'(k));
    end
    wait_drain();
  endtask

  initial begin
    logic ok;
    // Reset held with all requests pending: nothing may move.
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
    end
    run_all();

    send(0, 8'b1101_1000, 2);
    send(1, 8'hFF, 0);
    send(1, 8'h00, 0);
    send(1, 8'b0110_0110, 2);
    send(1, 8'b1100_1100, 2);
    send(3, 8'b0000_0011, 0);
    send(3, 8'b0000_0000, 0);

    // Abort ch2 mid-SHIFT with reset; no response may follow.
    req_data[2*WORD_W +: WORD_W] = 8'b1101_1000;
    req_valid[2] = 1'b1;
    wait_ready_any(ok);
    if (ok) check("abort_ready", 32'(req_ready), 32'b0100);
    @(posedge clock); #1;
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    rdy_q.delete();
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    check("abort_grant_id", 32'(grant_id), 32'd0);
    run_all();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
